// File: rtl/data_mem_responder.sv
// Data-memory responder for a single-cycle datapath: zero-latency reads, edge-committed writes,
// sticky misalign/range flags and saturating legal-access counters.
module data_mem_responder #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      memAddr,
    input  logic [63:0]      memWriteData,
    input  logic             MemWrite,
    input  logic             MemRead,
    output logic [63:0]      memReadData,
    input  logic             err_clr,
    output logic             err_misalign,
    output logic             err_range,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);

    localparam int unsigned IDX_W      = $clog2(DEPTH);
    localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) << 3;

    logic [63:0]      r_mem [DEPTH];
    logic             r_err_misalign;
    logic             r_err_range;
    logic [CNT_W-1:0] r_rd_count;
    logic [CNT_W-1:0] r_wr_count;

    logic [IDX_W-1:0] w_idx;
    logic             w_misalign;
    logic             w_out_range;
    logic             w_legal;
    logic             w_access;
    logic             w_rd_ok;
    logic             w_wr_ok;

    // Address decode and legality
    assign w_idx       = memAddr[IDX_W+2:3];
    assign w_misalign  = (memAddr[2:0] != 3'b000);
    assign w_out_range = (memAddr >= ADDR_LIMIT);
    assign w_legal     = ~w_misalign & ~w_out_range;
    assign w_access    = MemRead | MemWrite;
    assign w_rd_ok     = rst & MemRead & w_legal;
    assign w_wr_ok     = MemWrite & w_legal;

    // Read data is combinational; a same-cycle write lands only at the edge, so old data is returned
    assign memReadData = w_rd_ok ? r_mem[w_idx] : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_err_misalign <= 1'b0;
            r_err_range    <= 1'b0;
            r_rd_count     <= '0;
            r_wr_count     <= '0;
        end else begin
            if (w_wr_ok) begin
                r_mem[w_idx] <= memWriteData;
            end
            if (w_rd_ok && (r_rd_count != '1)) begin
                r_rd_count <= r_rd_count + CNT_W'(1);
            end
            if (w_wr_ok && (r_wr_count != '1)) begin
                r_wr_count <= r_wr_count + CNT_W'(1);
            end
            // Clear first, then a new illegal access sets the flag again (set wins)
            r_err_misalign <= (r_err_misalign & ~err_clr) | (w_access & w_misalign);
            r_err_range    <= (r_err_range & ~err_clr) | (w_access & w_out_range);
        end
    end

    assign err_misalign = r_err_misalign;
    assign err_range    = r_err_range;
    assign rd_count     = r_rd_count;
    assign wr_count     = r_wr_count;

endmodule
